arb4_ctrl: RTL

- Four-requester arbiter that shares one downstream resource (the encoder/adder datapath) among up to four clients.
- Priority is resolved with the same index encoding as the priority encoder: `gnt_id` is the 2-bit index of the granted line, and `gnt_v` is the valid flag.
- A grant persists while its requester holds `req` high, bounded by a hold-limit counter.
- Every grant is followed by a one-cycle dead gap before re-arbitration.

---
 rtl/arb4_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/arb4_ctrl.sv
// arb4_ctrl: 4-way arbiter with hold limit and one-cycle gap; define ARB4_CTRL_RR_EN for round-robin, else fixed priority
module arb4_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst_n,
  input logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic gnt_v,
  output logic timeout
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state, state_n;
  logic [3:0] gnt_n;
  logic [1:0] id_n, win;
  logic v_n, to_n, win_v;
  logic [CNT_W-1:0] cnt, cnt_n;
`ifdef ARB4_CTRL_RR_EN
  logic [1:0] last;
  always_comb begin
    win = last;
    win_v = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req[last + 2'(k)]) begin
        win = last + 2'(k);
        win_v = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) last <= 2'b11;
    else if (state != BUSY && win_v) last <= win;
  end
`else
  assign win = req[3] ? 2'd3 : req[2] ? 2'd2 : req[1] ? 2'd1 : 2'd0;
  assign win_v = |req;
`endif
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    id_n = gnt_id;
    v_n = gnt_v;
    to_n = 1'b0;
    cnt_n = cnt;
    if (state == BUSY) begin
      if (!req[gnt_id] || cnt == CNT_W'(MAX_HOLD)) begin
        state_n = GAP;
        gnt_n = 4'b0000;
        v_n = 1'b0;
        to_n = req[gnt_id];
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else begin
      state_n = win_v ? BUSY : IDLE;
      gnt_n = win_v ? 4'b0001 << win : 4'b0000;
      id_n = win_v ? win : gnt_id;
      v_n = win_v;
      cnt_n = win_v ? CNT_W'(1) : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= 4'b0000;
      gnt_id <= 2'b00;
      gnt_v <= 1'b0;
      timeout <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= id_n;
      gnt_v <= v_n;
      timeout <= to_n;
      cnt <= cnt_n;
    end
  end
endmodule
